// File: rtl/jogador_pkg.sv
// rtl/jogador_pkg.sv - shared state codes, LED constants and code-to-button helper for the automatic player
package jogador_pkg;

    typedef enum logic [2:0] {
        OCIOSO     = 3'd0,
        INICIA     = 3'd1,
        ESPERA_LED = 3'd2,
        CAPTURA    = 3'd3,
        SILENCIO   = 3'd4,
        PRESSIONA  = 3'd5,
        SOLTA      = 3'd6,
        FIM        = 3'd7
    } estado_t;

    localparam logic [2:0] LED_OFF = 3'd0;
    localparam logic [2:0] LED_MAX = 3'd4;

    function automatic logic [3:0] codigo_para_botao(input logic [1:0] codigo);
        return 4'b0001 << codigo;
    endfunction

endpackage

// File: rtl/memoria_jogador.sv
// rtl/memoria_jogador.sv - MAX_JOGADAS x 2-bit register file, synchronous write, combinational read
module memoria_jogador
    import jogador_pkg::*;
#(
    parameter int MAX_JOGADAS = 16,
    localparam int AW = (MAX_JOGADAS > 1) ? $clog2(MAX_JOGADAS) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_we,
    input  logic [AW-1:0] i_end_escrita,
    input  logic [1:0]    i_dado,
    input  logic [AW-1:0] i_end_leitura,
    output logic [1:0]    o_dado
);

    logic [1:0] r_mem [MAX_JOGADAS];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MAX_JOGADAS; i++) begin
                r_mem[i] <= 2'd0;
            end
        end else if (i_we) begin
            r_mem[i_end_escrita] <= i_dado;
        end
    end

    assign o_dado = r_mem[i_end_leitura];

endmodule

// File: rtl/jogador_automatico.sv
// rtl/jogador_automatico.sv - records the game's LED sequence and replays it as timed button presses
// Optional JOGADOR_ERRO_PROPOSITAL_EN: adds erro_idx to press a wrong button at one replay index.
module jogador_automatico
    import jogador_pkg::*;
#(
    parameter int MAX_JOGADAS     = 16,
    parameter int SILENCIO_CICLOS = 2000,
    parameter int T_PRESS         = 50,
    parameter int T_GAP           = 50
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilitar,
    input  logic [2:0] leds,
    input  logic       ganhou,
    input  logic       perdeu,
    input  logic       timeout,
`ifdef JOGADOR_ERRO_PROPOSITAL_EN
    input  logic [4:0] erro_idx,
`endif
    output logic       jogar,
    output logic [3:0] botoes,
    output logic       erro_captura,
    output logic       fim,
    output logic [3:0] db_estado,
    output logic [4:0] db_num_jogadas
);

    localparam int AW    = (MAX_JOGADAS > 1) ? $clog2(MAX_JOGADAS) : 1;
    localparam int CW    = $clog2(MAX_JOGADAS) + 1;
    localparam int SW    = $clog2(SILENCIO_CICLOS) + 1;
    localparam int T_MAX = (T_PRESS > T_GAP) ? T_PRESS : T_GAP;
    localparam int TW    = $clog2(T_MAX) + 1;

    estado_t         r_estado;
    logic [CW-1:0]   r_num;
    logic [CW-1:0]   r_idx;
    logic [SW-1:0]   r_sil;
    logic [TW-1:0]   r_tempo;
    logic [2:0]      r_ultimo;
    logic            r_primeira;

    logic            w_fim_jogo;
    logic            w_bloqueio;
    logic            w_em_captura;
    logic            w_codigo_novo;
    logic            w_codigo_invalido;
    logic            w_cheio;
    logic            w_captura;
    logic            w_grava;
    logic [AW-1:0]   w_end_escrita;
    logic [1:0]      w_dado_escrita;
    logic [CW-1:0]   w_idx_proximo;
    logic [1:0]      w_mem_dado;
    logic [3:0]      w_botao;

    memoria_jogador #(.MAX_JOGADAS(MAX_JOGADAS)) u_memoria (
        .clock         (clock),
        .reset         (reset),
        .i_we          (w_grava),
        .i_end_escrita (w_end_escrita),
        .i_dado        (w_dado_escrita),
        .i_end_leitura (w_idx_proximo[AW-1:0]),
        .o_dado        (w_mem_dado)
    );

    always_comb begin
        w_fim_jogo        = ganhou | perdeu | timeout;
        w_bloqueio        = !habilitar || (w_fim_jogo && r_estado != OCIOSO);
        w_em_captura      = (r_estado == ESPERA_LED) || (r_estado == CAPTURA) || (r_estado == SILENCIO);
        // Holding the same code in CAPTURA is one entry; only a change counts as new
        w_codigo_novo     = (leds != LED_OFF) && !(r_estado == CAPTURA && leds == r_ultimo);
        w_codigo_invalido = leds > LED_MAX;
        w_cheio           = !r_primeira && (r_num == CW'(MAX_JOGADAS));
        w_captura         = w_em_captura && w_codigo_novo && !w_bloqueio;
        w_grava           = w_captura && !w_codigo_invalido && !w_cheio;
        w_end_escrita     = r_primeira ? '0 : r_num[AW-1:0];
        w_dado_escrita    = leds[1:0] - 2'd1;
        w_idx_proximo     = (r_estado == SOLTA) ? r_idx + 1'b1 : '0;
        w_botao           = codigo_para_botao(w_mem_dado);
`ifdef JOGADOR_ERRO_PROPOSITAL_EN
        if (5'(w_idx_proximo) == erro_idx) begin
            w_botao = codigo_para_botao(w_mem_dado + 2'd1);
        end
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado     <= OCIOSO;
            r_num        <= '0;
            r_idx        <= '0;
            r_sil        <= '0;
            r_tempo      <= '0;
            r_ultimo     <= LED_OFF;
            r_primeira   <= 1'b1;
            jogar        <= 1'b0;
            botoes       <= 4'd0;
            erro_captura <= 1'b0;
            fim          <= 1'b0;
        end else begin
            jogar <= 1'b0;
            if (!habilitar) begin
                r_estado <= OCIOSO;
                botoes   <= 4'd0;
                fim      <= 1'b0;
            end else if (w_fim_jogo && r_estado != OCIOSO) begin
                r_estado <= FIM;
                botoes   <= 4'd0;
                fim      <= 1'b1;
            end else if (w_captura && (w_codigo_invalido || w_cheio)) begin
                erro_captura <= 1'b1;
                r_estado     <= FIM;
                fim          <= 1'b1;
            end else if (w_grava) begin
                r_num      <= r_primeira ? CW'(1) : r_num + 1'b1;
                r_primeira <= 1'b0;
                r_ultimo   <= leds;
                r_estado   <= CAPTURA;
            end else begin
                case (r_estado)
                    OCIOSO: begin
                        r_estado     <= INICIA;
                        jogar        <= 1'b1;
                        erro_captura <= 1'b0;
                        r_primeira   <= 1'b1;
                    end
                    INICIA: r_estado <= ESPERA_LED;
                    CAPTURA: begin
                        if (leds == LED_OFF) begin
                            r_sil    <= '0;
                            r_estado <= SILENCIO;
                        end
                    end
                    SILENCIO: begin
                        if (r_sil == SW'(SILENCIO_CICLOS - 1)) begin
                            r_idx    <= '0;
                            r_tempo  <= '0;
                            botoes   <= w_botao;
                            r_estado <= PRESSIONA;
                        end else begin
                            r_sil <= r_sil + 1'b1;
                        end
                    end
                    PRESSIONA: begin
                        if (r_tempo == TW'(T_PRESS - 1)) begin
                            r_tempo  <= '0;
                            botoes   <= 4'd0;
                            r_estado <= SOLTA;
                        end else begin
                            r_tempo <= r_tempo + 1'b1;
                        end
                    end
                    SOLTA: begin
                        if (r_tempo == TW'(T_GAP - 1)) begin
                            r_tempo <= '0;
                            if (r_idx == r_num - 1'b1) begin
                                r_primeira <= 1'b1;
                                r_estado   <= ESPERA_LED;
                            end else begin
                                r_idx    <= w_idx_proximo;
                                botoes   <= w_botao;
                                r_estado <= PRESSIONA;
                            end
                        end else begin
                            r_tempo <= r_tempo + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign db_estado      = {1'b0, r_estado};
    assign db_num_jogadas = 5'(r_num);

endmodule

// File: tb/tb_jogador_automatico.sv
// tb/tb_jogador_automatico.sv - self-checking bench for jogador_automatico (vector table plus press scoreboard)
module tb_jogador_automatico;

    logic       clock = 1'b0;
    logic       reset;
    logic       habilitar;
    logic [2:0] leds;
    logic       ganhou;
    logic       perdeu;
    logic       timeout;
`ifdef JOGADOR_ERRO_PROPOSITAL_EN
    logic [4:0] erro_idx;
`endif
    logic       jogar;
    logic [3:0] botoes;
    logic       erro_captura;
    logic       fim;
    logic [3:0] db_estado;
    logic [4:0] db_num_jogadas;

    jogador_automatico dut (
        .clock          (clock),
        .reset          (reset),
        .habilitar      (habilitar),
        .leds           (leds),
        .ganhou         (ganhou),
        .perdeu         (perdeu),
        .timeout        (timeout),
`ifdef JOGADOR_ERRO_PROPOSITAL_EN
        .erro_idx       (erro_idx),
`endif
        .jogar          (jogar),
        .botoes         (botoes),
        .erro_captura   (erro_captura),
        .fim            (fim),
        .db_estado      (db_estado),
        .db_num_jogadas (db_num_jogadas)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    logic [3:0] sb_q[$];
    bit mon_on = 1'b0;

    task automatic check(input string nome, input int atual, input int esperado);
        checks++;
        if (atual != esperado) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nome, atual, esperado);
        end
    endtask

    // Press monitor: each new press is compared with the next expected button
    logic [3:0] m_prev = 4'd0;
    int         m_len  = 0;
    always @(negedge clock) begin
        if (mon_on) begin
            if (botoes != 4'd0 && m_prev == 4'd0) begin
                m_len = 1;
                if (sb_q.size() == 0) check("press_unexpected", int'(botoes), 0);
                else check("press_value", int'(botoes), int'(sb_q.pop_front()));
            end else if (botoes != 4'd0) begin
                m_len++;
            end else if (m_prev != 4'd0) begin
                check("press_len", m_len, 50);
            end
        end
        m_prev = botoes;
    end

    function automatic logic [2:0] eco(input logic [3:0] b);
        case (b)
            4'b0001: return 3'd1;
            4'b0010: return 3'd2;
            4'b0100: return 3'd3;
            4'b1000: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    task automatic ciclos(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic mostra(input logic [2:0] c, input int n);
        leds = c;
        ciclos(n);
    endtask

    task automatic reinicia();
        habilitar = 1'b0;
        @(negedge clock);
        habilitar = 1'b1;
        ciclos(3);
    endtask

    task automatic espera_replay(input string nome);
        int lim;
        lim = 0;
        while (!(sb_q.size() == 0 && db_estado == 4'd2) && lim < 4000) begin
            leds = eco(botoes);
            @(negedge clock);
            lim++;
        end
        leds = 3'd0;
        check(nome, int'(lim < 4000), 1);
    endtask

    task automatic espera_botao(input string nome);
        int lim;
        lim = 0;
        while (botoes == 4'd0 && lim < 2500) begin
            @(negedge clock);
            lim++;
        end
        check(nome, int'(botoes != 4'd0), 1);
    endtask

    typedef struct {
        int              n;
        logic [3:0][2:0] cod;
        bit              gap;
        logic [3:0][3:0] esp;
        int              num;
    } vetor_t;

    vetor_t tab[5];

    initial begin
        int nj;
        tab[0] = '{2, {3'd0, 3'd0, 3'd3, 3'd1}, 1'b1, {4'h0, 4'h0, 4'h4, 4'h1}, 2};
        tab[1] = '{2, {3'd0, 3'd0, 3'd4, 3'd2}, 1'b0, {4'h0, 4'h0, 4'h8, 4'h2}, 2};
        tab[2] = '{3, {3'd0, 3'd1, 3'd4, 3'd4}, 1'b1, {4'h0, 4'h1, 4'h8, 4'h8}, 3};
        tab[3] = '{1, {3'd0, 3'd0, 3'd0, 3'd3}, 1'b1, {4'h0, 4'h0, 4'h0, 4'h4}, 1};
        tab[4] = '{4, {3'd4, 3'd3, 3'd2, 3'd1}, 1'b0, {4'h8, 4'h4, 4'h2, 4'h1}, 4};

        reset = 1'b0; habilitar = 1'b0; leds = 3'd0;
        ganhou = 1'b0; perdeu = 1'b0; timeout = 1'b0;
`ifdef JOGADOR_ERRO_PROPOSITAL_EN
        erro_idx = 5'd31;
`endif
        ciclos(3);
        check("rst_estado", int'(db_estado), 0);
        check("rst_botoes", int'(botoes), 0);
        check("rst_jogar", int'(jogar), 0);
        check("rst_erro", int'(erro_captura), 0);
        check("rst_fim", int'(fim), 0);
        check("rst_num", int'(db_num_jogadas), 0);
        reset = 1'b1;
        ciclos(2);
        check("idle_sem_habilitar", int'(db_estado), 0);

        habilitar = 1'b1;
        nj = 0;
        repeat (10) begin
            @(negedge clock);
            if (jogar) nj++;
        end
        check("jogar_um_ciclo", nj, 1);
        check("inicio_espera_led", int'(db_estado), 2);
        check("inicio_botoes", int'(botoes), 0);

        mon_on = 1'b1;
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < tab[v].n; i++) begin
                mostra(tab[v].cod[i], 20);
                if (tab[v].gap && i != tab[v].n - 1) mostra(3'd0, 20);
            end
            leds = 3'd0;
            for (int i = 0; i < tab[v].n; i++) sb_q.push_back(tab[v].esp[i]);
            espera_replay($sformatf("v%0d_replay_fim", v));
            check($sformatf("v%0d_num", v), int'(db_num_jogadas), tab[v].num);
            check($sformatf("v%0d_erro", v), int'(erro_captura), 0);
            check($sformatf("v%0d_botoes", v), int'(botoes), 0);
        end
        mon_on = 1'b0;

        mostra(3'd1, 20);
        mostra(3'd0, 30);
        check("silencio_estado", int'(db_estado), 4);
        leds = 3'd6;
        @(negedge clock);
        leds = 3'd0;
        check("invalido_erro", int'(erro_captura), 1);
        check("invalido_fim", int'(fim), 1);
        check("invalido_botoes", int'(botoes), 0);
        check("invalido_estado", int'(db_estado), 7);
        habilitar = 1'b0;
        @(negedge clock);
        check("abort_estado", int'(db_estado), 0);
        check("abort_fim", int'(fim), 0);
        check("erro_pegajoso", int'(erro_captura), 1);
        habilitar = 1'b1;
        ciclos(3);
        check("erro_limpo_inicia", int'(erro_captura), 0);
        check("reinicio_estado", int'(db_estado), 2);

        for (int i = 0; i < 16; i++) mostra(3'((i % 2) + 1), 2);
        check("cheio_num", int'(db_num_jogadas), 16);
        check("cheio_sem_erro", int'(erro_captura), 0);
        leds = 3'd1;
        @(negedge clock);
        leds = 3'd0;
        check("overflow_erro", int'(erro_captura), 1);
        check("overflow_fim", int'(fim), 1);
        check("overflow_num", int'(db_num_jogadas), 16);
        reinicia();

        mostra(3'd3, 20);
        leds = 3'd0;
        espera_botao("perdeu_press_inicio");
        ciclos(10);
        check("perdeu_press_valor", int'(botoes), 4);
        perdeu = 1'b1;
        @(negedge clock);
        perdeu = 1'b0;
        check("perdeu_botoes", int'(botoes), 0);
        check("perdeu_fim", int'(fim), 1);
        check("perdeu_estado", int'(db_estado), 7);
        reinicia();

        ganhou = 1'b1;
        @(negedge clock);
        ganhou = 1'b0;
        check("ganhou_estado", int'(db_estado), 7);
        reinicia();

        timeout = 1'b1;
        habilitar = 1'b0;
        @(negedge clock);
        timeout = 1'b0;
        check("prioridade_habilitar", int'(db_estado), 0);
        check("prioridade_fim", int'(fim), 0);
        habilitar = 1'b1;
        ciclos(3);

`ifdef JOGADOR_ERRO_PROPOSITAL_EN
        mon_on = 1'b1;
        erro_idx = 5'd1;
        mostra(3'd1, 20);
        mostra(3'd0, 20);
        mostra(3'd1, 20);
        leds = 3'd0;
        sb_q.push_back(4'b0001);
        sb_q.push_back(4'b0010);
        espera_replay("erro_proposital_replay");
        erro_idx = 5'd31;
        mon_on = 1'b0;
`endif

        mostra(3'd2, 20);
        leds = 3'd0;
        espera_botao("reset_press_inicio");
        check("reset_press_valor", int'(botoes), 2);
        #2 reset = 1'b0;
        #1;
        check("reset_async_botoes", int'(botoes), 0);
        check("reset_async_estado", int'(db_estado), 0);
        @(negedge clock);
        reset = 1'b1;
        ciclos(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
